// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types and default widths for the register-file write path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int REGFILE_SEL_W  = 5;
  localparam int REGFILE_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [REGFILE_SEL_W-1:0]  sel;
    logic [REGFILE_DATA_W-1:0] data;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
// Module   : onehot_decoder
// Brief    : Select-to-one-hot decode gated by en_in, with optional index-0 mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder #(
  parameter int SEL_W     = 5,
  parameter int ZERO_MASK = 1
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en_in,
  output logic [2**SEL_W-1:0]   onehot_out
);

  localparam int OUTS = 2**SEL_W;

  logic [OUTS-1:0] raw_onehot;

  always_comb begin
    raw_onehot      = '0;
    raw_onehot[sel] = en_in;
  end

  generate
    if (ZERO_MASK != 0) begin : g_zero_mask
      assign onehot_out = {raw_onehot[OUTS-1:1], 1'b0};
    end else begin : g_no_mask
      assign onehot_out = raw_onehot;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_wen_demux.sv
// ============================================================================
// Module   : regfile_wen_demux
// Brief    : 2-entry skid-buffered write-enable demux for the register array.
//            Optional counters enabled by REGFILE_WEN_DEMUX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wen_demux
  import regfile_pkg::*;
#(
  parameter int SEL_W     = REGFILE_SEL_W,
  parameter int DATA_W    = REGFILE_DATA_W,
  parameter int ZERO_MASK = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**SEL_W-1:0]  out_en,
  output logic [SEL_W-1:0]     out_sel,
  output logic [DATA_W-1:0]    out_data
`ifdef REGFILE_WEN_DEMUX_STATS_EN
  ,
  output logic [15:0]          stat_masked,
  output logic [15:0]          stat_stall
`endif
);

  localparam int OUTS = 2**SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } slot_t;

  state_e state_q, state_d;
  slot_t  head_q, head_d;
  slot_t  skid_q, skid_d;
  slot_t  in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry  = '{sel: in_sel, data: in_data};
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_sel   = head_q.sel;
  assign out_data  = head_q.data;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Enable derives only from registered state, so it cannot glitch within a cycle.
  onehot_decoder #(
    .SEL_W     (SEL_W),
    .ZERO_MASK (ZERO_MASK)
  ) u_decoder (
    .sel        (head_q.sel),
    .en_in      (out_valid),
    .onehot_out (out_en)
  );

`ifdef REGFILE_WEN_DEMUX_STATS_EN
  logic [15:0] stat_masked_q, stat_masked_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic        masked_retire;

  assign masked_retire = (ZERO_MASK != 0) && out_fire && (head_q.sel == '0);

  always_comb begin
    stat_masked_d = stat_masked_q;
    stat_stall_d  = stat_stall_q;
    if (masked_retire && (stat_masked_q != 16'hFFFF)) begin
      stat_masked_d = stat_masked_q + 16'd1;
    end
    if (in_valid && !in_ready && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_masked_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_masked_q <= stat_masked_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_masked = stat_masked_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wen_demux.sv
// ============================================================================
// Module   : tb_regfile_wen_demux
// Brief    : Directed self-checking bench for regfile_wen_demux (masked and
//            unmasked instances); covers REGFILE_WEN_DEMUX_STATS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wen_demux;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_sel;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready,  nm_in_ready;
  logic        out_valid, nm_out_valid;
  logic [31:0] out_en,    nm_out_en;
  logic [4:0]  out_sel,   nm_out_sel;
  logic [31:0] out_data,  nm_out_data;
`ifdef REGFILE_WEN_DEMUX_STATS_EN
  logic [15:0] stat_masked, stat_stall, nm_stat_masked, nm_stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  regfile_wen_demux #(.SEL_W(5), .DATA_W(32), .ZERO_MASK(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_en(out_en), .out_sel(out_sel), .out_data(out_data)
`ifdef REGFILE_WEN_DEMUX_STATS_EN
    , .stat_masked(stat_masked), .stat_stall(stat_stall)
`endif
  );

  regfile_wen_demux #(.SEL_W(5), .DATA_W(32), .ZERO_MASK(0)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(nm_out_valid),
    .out_ready(out_ready), .out_en(nm_out_en), .out_sel(nm_out_sel), .out_data(nm_out_data)
`ifdef REGFILE_WEN_DEMUX_STATS_EN
    , .stat_masked(nm_stat_masked), .stat_stall(nm_stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_en",    64'(out_en),    64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // Single write
    in_valid = 1'b1; in_sel = 5'd5; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid",    64'(out_valid), 64'd1);
    check("single_en",       64'(out_en),    64'h0000_0020);
    check("single_data",     64'(out_data),  64'hDEADBEEF);
    check("single_in_ready", 64'(in_ready),  64'd1);
    tick();
    check("single_retired_valid", 64'(out_valid), 64'd0);
    check("single_retired_en",    64'(out_en),    64'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 5'd1; in_data = 32'hA1;
    tick();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    check("bp1_sel",      64'(out_sel),  64'd1);
    in_sel = 5'd2; in_data = 32'hA2;
    tick();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check("bp2_sel",      64'(out_sel),  64'd1);
    check("bp2_en",       64'(out_en),   64'h2);
    in_sel = 5'd3; in_data = 32'hA3;
    tick();
    check("bp3_in_ready", 64'(in_ready), 64'd0);
    check("bp3_sel_held", 64'(out_sel),  64'd1);
    check("bp3_data_held", 64'(out_data), 64'hA1);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_sel",      64'(out_sel),  64'd2);
    check("bp_rel1_data",     64'(out_data), 64'hA2);
    check("bp_rel1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_rel2_sel",  64'(out_sel),  64'd3);
    check("bp_rel2_data", 64'(out_data), 64'hA3);
    check("bp_rel2_en",   64'(out_en),   64'h8);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // x0 masking
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 5'd0; in_data = 32'h1234;
    tick();
    in_valid = 1'b0;
    check("mask_valid",    64'(out_valid),    64'd1);
    check("mask_en",       64'(out_en),       64'd0);
    check("mask_data",     64'(out_data),     64'h1234);
    check("nomask_en",     64'(nm_out_en),    64'd1);
    check("nomask_valid",  64'(nm_out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("mask_retired",   64'(out_valid),    64'd0);
    check("nomask_retired", 64'(nm_out_valid), 64'd0);

    // Streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_sel  = 5'(i);
      in_data = 32'(i * 3 + 32'h100);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_en",    64'(out_en),    (i == 0) ? 64'd0 : (64'd1 << i));
      check("stream_nm_en", 64'(nm_out_en), 64'd1 << i);
      check("stream_data",  64'(out_data),  64'(i * 3 + 32'h100));
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Mid-operation reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 5'd7; in_data = 32'h77;
    tick();
    in_sel = 5'd8; in_data = 32'h88;
    tick();
    in_valid = 1'b0;
    check("full_before_reset", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid",    64'(out_valid), 64'd0);
    check("midrst_en",       64'(out_en),    64'd0);
    check("midrst_in_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_ghost", 64'(out_valid), 64'd0);
    end

`ifdef REGFILE_WEN_DEMUX_STATS_EN
    check("stats_cleared_masked", 64'(stat_masked), 64'd0);
    check("stats_cleared_stall",  64'(stat_stall),  64'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 5'd0; in_data = 32'h5;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    check("stats_masked3",    64'(stat_masked),    64'd3);
    check("stats_nm_masked0", 64'(nm_stat_masked), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 5'd4; in_data = 32'h44;
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("stats_stall4", 64'(stat_stall), 64'd4);
    check("stats_masked_held", 64'(stat_masked), 64'd3);
    repeat (70000) @(posedge clk);
    #1;
    check("stats_stall_sat", 64'(stat_stall), 64'hFFFF);
    in_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
